mem_sequencer: RTL

Multi-cycle memory sequencer that lets the 16-bit CPU core share one synchronous single-port 256x16 RAM for instruction fetch, data load/store and host access. Sits between the `mips` core and the RAM, presents the latched instruction and load data to the core, and gates core state updates with a one-cycle execute enable. It also detects HALT and gives a host port word access at instruction boundaries.

---
 rtl/cpu_defs.sv | 36 +++
 rtl/mem_sequencer.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/cpu_defs.sv
// Definitions shared by the 16-bit core decoder and the memory sequencer:
// opcode field values and the sequencer state encoding.
package cpu_defs;

  // Opcode field, instr[15:11]
  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_NOP   = 5'b00001;
  localparam logic [4:0] OP_BEQ   = 5'b00100;
  localparam logic [4:0] OP_LOAD  = 5'b10001;
  localparam logic [4:0] OP_ADDI  = 5'b10011;
  localparam logic [4:0] OP_STORE = 5'b10101;
  localparam logic [4:0] OP_HALT  = 5'b11011;

  typedef enum logic [2:0] {
    S_FETCH,
    S_IWAIT,
    S_DREAD,
    S_DWAIT,
    S_EXEC,
    S_HALT,
    S_HOST,
    S_HWAIT
  } seq_state_t;

  // State that follows S_IWAIT for a freshly fetched opcode.
  function automatic seq_state_t after_fetch(input logic [4:0] op);
    seq_state_t nxt;
    case (op)
      OP_HALT: nxt = S_HALT;
      OP_LOAD: nxt = S_DREAD;
      default: nxt = S_EXEC;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/mem_sequencer.sv
// Shares one synchronous single-port RAM between instruction fetch, core
// load/store and a host port; gates core updates with a one-cycle enable.
module mem_sequencer
  import cpu_defs::*;
#(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 16
) (
  input  logic          clk,
  input  logic          reset,
  // core side
  input  logic [AW-1:0] pc,
  input  logic [DW-1:0] aluout,
  input  logic          memwrite,
  input  logic [DW-1:0] writedata,
  output logic [DW-1:0] instr,
  output logic [DW-1:0] readdata,
  output logic          cpu_en,
  // RAM port
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  // host port
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic [DW-1:0] host_rdata,
  output logic          host_ack,
  input  logic          host_run,
  output logic          halted
);

  seq_state_t    state_q, state_d;
  logic          ret_halt_q, ret_halt_d;
  logic          host_wr_q;
  logic [DW-1:0] instr_q, readdata_q, host_rdata_q;
  logic [AW-1:0] data_addr;
  logic [4:0]    fetched_op;

  // Only the low address bits of the ALU result reach the RAM.
  assign data_addr  = aluout[AW-1:0];
  assign fetched_op = mem_rdata[DW-1 -: 5];

  logic unused_alu_hi;
  assign unused_alu_hi = ^aluout[DW-1:AW];

  always_comb begin
    state_d    = state_q;
    ret_halt_d = ret_halt_q;
    cpu_en     = 1'b0;
    mem_addr   = '0;
    mem_we     = 1'b0;
    mem_wdata  = '0;
    host_ack   = 1'b0;
    halted     = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        if (host_req) begin
          state_d    = S_HOST;
          ret_halt_d = 1'b0;
        end else begin
          mem_addr = pc;
          state_d  = S_IWAIT;
        end
      end
      S_IWAIT: state_d = after_fetch(fetched_op);
      S_DREAD: begin
        mem_addr = data_addr;
        state_d  = S_DWAIT;
      end
      S_DWAIT: state_d = S_EXEC;
      S_EXEC: begin
        cpu_en    = 1'b1;
        mem_addr  = data_addr;
        mem_we    = memwrite;
        mem_wdata = writedata;
        state_d   = S_FETCH;
      end
      S_HALT: begin
        halted = 1'b1;
        // A run pulse arriving together with a host request is dropped.
        if (host_req) begin
          state_d    = S_HOST;
          ret_halt_d = 1'b1;
        end else if (host_run) begin
          state_d = S_FETCH;
        end
      end
      S_HOST: begin
        mem_addr  = host_addr;
        mem_we    = host_we;
        mem_wdata = host_wdata;
        state_d   = S_HWAIT;
      end
      S_HWAIT: begin
        host_ack = 1'b1;
        state_d  = ret_halt_q ? S_HALT : S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    // Nothing may leave the sequencer while reset is held.
    if (reset) begin
      cpu_en    = 1'b0;
      mem_addr  = '0;
      mem_we    = 1'b0;
      mem_wdata = '0;
      host_ack  = 1'b0;
      halted    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_FETCH;
      ret_halt_q   <= 1'b0;
      host_wr_q    <= 1'b0;
      instr_q      <= '0;
      readdata_q   <= '0;
      host_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      ret_halt_q <= ret_halt_d;
      if (state_q == S_IWAIT) instr_q <= mem_rdata;
      if (state_q == S_DWAIT) readdata_q <= mem_rdata;
      if (state_q == S_HOST) host_wr_q <= host_we;
      if ((state_q == S_HWAIT) && !host_wr_q) host_rdata_q <= mem_rdata;
    end
  end

  assign instr      = instr_q;
  assign readdata   = readdata_q;
  assign host_rdata = host_rdata_q;

  a_we_only_exec_host: assert property (@(posedge clk) disable iff (reset)
    mem_we |-> (state_q inside {S_EXEC, S_HOST}));

  a_cpu_en_single: assert property (@(posedge clk) disable iff (reset)
    cpu_en |=> !cpu_en);

endmodule
